scalar_product_seq: RTL and testbench



---
 rtl/scalar_product_pkg.sv | 18 +
 rtl/scalar_product_seq_mac_unit.sv | 36 +++
 rtl/scalar_product_seq.sv | 100 ++++++++++
 tb/tb_scalar_product_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/scalar_product_pkg.sv
// Shared definitions for the sequential scalar-product engine.
//   state_t : FSM states (ACC accumulates pairs, DONE presents the result)
//   out_w() : full-precision result width for NDATA products of NBITS operands
package scalar_product_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Each product needs 2*NBITS bits. Summing NDATA of them needs
  // $clog2(NDATA) more bits. $clog2(1)=0, so a single-element vector
  // needs no growth.
  function automatic int out_w(input int nbits, input int ndata);
    return 2 * nbits + $clog2(ndata);
  endfunction

endpackage

// File: rtl/scalar_product_seq_mac_unit.sv
// Extend-multiply-add slice: sum = acc + a*b.
//   a, b : NBITS operands, signed two's complement when SIGNED=1
//   acc  : running accumulator, OUT_W bits
//   sum  : acc + product, OUT_W bits
// The product is formed at 2*NBITS and then extended to OUT_W. OUT_W is
// sized for the worst case, so the addition can never overflow.
module mac_unit #(
  parameter int NBITS  = 4,
  parameter int SIGNED = 0,
  parameter int OUT_W  = 10
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [OUT_W-1:0] acc,
  output logic [OUT_W-1:0] sum
);

  logic [OUT_W-1:0] prod_ext;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*NBITS-1:0] prod_s;
      assign prod_s   = $signed(a) * $signed(b);
      // The size cast keeps the signedness of prod_s, so the result is
      // sign-extended.
      assign prod_ext = OUT_W'(prod_s);
    end else begin : g_unsigned
      logic [2*NBITS-1:0] prod_u;
      assign prod_u   = {{NBITS{1'b0}}, a} * {{NBITS{1'b0}}, b};
      assign prod_ext = OUT_W'(prod_u);
    end
  endgenerate

  assign sum = acc + prod_ext;

endmodule

// File: rtl/scalar_product_seq.sv
// Streaming dot-product engine. It takes one (a, b) pair per cycle and
// produces sum(a[i]*b[i]) over NDATA elements.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   clr                 : synchronous abort of the partial vector (ignored in DONE)
//   in_valid/in_ready   : input handshake for a_in/b_in
//   out_valid/out_ready : result handshake for out_data
//   busy                : the current vector has at least one accepted element
module scalar_product_seq
  import scalar_product_pkg::*;
#(
  parameter int NBITS  = 4,
  parameter int NDATA  = 3,
  parameter int SIGNED = 0,
  parameter int OUT_W  = out_w(NBITS, NDATA)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a_in,
  input  logic [NBITS-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  localparam int               IDX_W    = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDATA - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [OUT_W-1:0] acc, acc_next;
  logic [OUT_W-1:0] out_data_next;
  logic [OUT_W-1:0] mac_sum;

  mac_unit #(
    .NBITS (NBITS),
    .SIGNED(SIGNED),
    .OUT_W (OUT_W)
  ) u_mac (
    .a  (a_in),
    .b  (b_in),
    .acc(acc),
    .sum(mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      idx      <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      acc      <= acc_next;
      out_data <= out_data_next;
    end
  end

  // The handshake outputs depend only on state. This keeps out_ready and
  // in_valid off any combinational path to in_ready.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    acc_next      = acc;
    out_data_next = out_data;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (clr) begin
          // clr takes priority over a pair offered in the same cycle.
          acc_next = '0;
          idx_next = '0;
        end else if (in_valid) begin
          if (idx == IDX_LAST) begin
            out_data_next = mac_sum;
            acc_next      = '0;
            idx_next      = '0;
            state_next    = DONE;
          end else begin
            acc_next = mac_sum;
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
    endcase
  end

  assign busy = (state == ACC) && (idx != '0);

endmodule

// File: tb/tb_scalar_product_seq.sv
// Self-checking bench for scalar_product_seq.
// Two instances share the same inputs: one unsigned and one signed, both
// with NBITS=4 and NDATA=3. Each vector therefore checks both views of the
// same bit patterns.
module tb_scalar_product_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;

  logic       u_in_ready, u_out_valid, u_busy;
  logic [9:0] u_out_data;
  logic       s_in_ready, s_out_valid, s_busy;
  logic [9:0] s_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scalar_product_seq #(.NBITS(4), .NDATA(3), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(u_in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .busy(u_busy)
  );

  scalar_product_seq #(.NBITS(4), .NDATA(3), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .busy(s_busy)
  );

  typedef struct {
    string       name;
    logic [11:0] a;      // element i in nibble i
    logic [11:0] b;
    int          exp_u;
    int          exp_s;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference dot product from the spec's arithmetic rule, masked to 10 bits.
  function automatic logic [31:0] model(input logic [11:0] a, input logic [11:0] b, input bit sgn);
    int sum = 0;
    for (int i = 0; i < 3; i++) begin
      logic [3:0]        au, bu;
      logic signed [3:0] as, bs;
      au = a[4*i +: 4];
      bu = b[4*i +: 4];
      as = au;
      bs = bu;
      if (sgn) sum += int'(as) * int'(bs);
      else     sum += int'(au) * int'(bu);
    end
    return 32'(sum) & 32'h3FF;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_u_out_valid"}, 32'(u_out_valid), 0);
    check({tag, "_u_in_ready"},  32'(u_in_ready), 1);
    check({tag, "_u_busy"},      32'(u_busy), 0);
    check({tag, "_u_out_data"},  32'(u_out_data), 0);
    check({tag, "_s_out_valid"}, 32'(s_out_valid), 0);
    check({tag, "_s_out_data"},  32'(s_out_data), 0);
  endtask

  // Offer one pair on the next negedge; it is accepted on the following posedge.
  task automatic offer(input logic [3:0] a, input logic [3:0] b, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    check({tag, "_in_ready"}, 32'(u_in_ready & s_in_ready), 1);
  endtask

  // Send a full vector, optionally with random idle gaps, and leave the result pending.
  task automatic send_vec(input logic [11:0] a, input logic [11:0] b, input bit gaps, input string tag);
    for (int i = 0; i < 3; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          in_valid = 1'b0;
          a_in = 4'($urandom);
          b_in = 4'($urandom);
        end
      end
      offer(a[4*i +: 4], b[4*i +: 4], tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_latency_out_valid"}, 32'(u_out_valid & s_out_valid), 1);
  endtask

  task automatic take_result(input logic [31:0] exp_u, input logic [31:0] exp_s, input string tag);
    check({tag, "_u_data"}, 32'(u_out_data), exp_u & 32'h3FF);
    check({tag, "_s_data"}, 32'(s_out_data), exp_s & 32'h3FF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_to_acc"}, 32'({u_out_valid, s_out_valid, u_in_ready, s_in_ready}), 32'b0011);
  endtask

  initial begin
    logic [9:0] held_u, held_s;

    tbl[0] = '{"basic",   12'h321, 12'h654, 32,  32};
    tbl[1] = '{"max",     12'hFFF, 12'hFFF, 675, 3};
    tbl[2] = '{"ones",    12'h111, 12'h111, 3,   3};
    tbl[3] = '{"neg8",    12'h888, 12'h888, 192, 192};
    tbl[4] = '{"mixed",   12'h187, 12'h078, 112, -112};

    // Reset state, with reset asserted.
    #2;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // Table-driven vectors, back to back.
    for (int t = 0; t < 5; t++) begin
      send_vec(tbl[t].a, tbl[t].b, 1'b0, tbl[t].name);
      take_result(32'(tbl[t].exp_u), 32'(tbl[t].exp_s), tbl[t].name);
    end

    // Backpressure: DONE holds, no pair consumed.
    send_vec(12'h321, 12'h654, 1'b0, "bp");
    held_u = u_out_data;
    held_s = s_out_data;
    in_valid = 1'b1;
    a_in = 4'h7;
    b_in = 4'h7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(u_in_ready | s_in_ready), 0);
      check("bp_out_valid",    32'(u_out_valid & s_out_valid), 1);
      check("bp_data_stable",  32'({u_out_data, s_out_data}), 32'({held_u, held_s}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_release", 32'({u_out_valid, u_in_ready, u_busy}), 32'b010);
    send_vec(12'h111, 12'h111, 1'b0, "bp_after");
    take_result(3, 3, "bp_after");

    // clr after two pairs, with clr winning over a pair offered in the same cycle.
    offer(4'h5, 4'h5, "clr_p0");
    offer(4'h6, 4'h6, "clr_p1");
    @(negedge clk);
    check("clr_busy_before", 32'(u_busy & s_busy), 1);
    clr = 1'b1;
    in_valid = 1'b1;
    a_in = 4'h9;
    b_in = 4'h9;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_busy_after", 32'(u_busy | s_busy), 0);
    send_vec(12'h321, 12'h654, 1'b0, "clr_vec");
    // clr in DONE must not disturb the result.
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check("clr_done_valid", 32'(u_out_valid & s_out_valid), 1);
    take_result(32, 32, "clr_done");

    // Asynchronous reset mid-vector (idx=1).
    offer(4'h3, 4'h3, "rst_mid");
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_busy", 32'(u_busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    // Asynchronous reset in DONE.
    send_vec(12'hFFF, 12'hFFF, 1'b0, "rst_done_pre");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    send_vec(12'h321, 12'h654, 1'b0, "rst_after");
    take_result(32, 32, "rst_after");

    // Random vectors with idle gaps, checked against the reference model.
    for (int r = 0; r < 25; r++) begin
      logic [11:0] ra, rb;
      ra = 12'($urandom);
      rb = 12'($urandom);
      send_vec(ra, rb, 1'b1, "rand");
      take_result(model(ra, rb, 1'b0), model(ra, rb, 1'b1), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
